// File: rtl/uart_frame_receiver_if.sv
// Frame handshake between the UART frame receiver and its consumer.
// Signals follow the uart_controller i_UART_DATA_TX layout: header byte in [39:32].
interface uart_frame_receiver_if;
  logic [39:0] o_FRAME_DATA;
  logic        o_FRAME_LONG;
  logic        o_FRAME_VALID;
  logic        i_FRAME_READY;

  modport master (
    output o_FRAME_DATA,
    output o_FRAME_LONG,
    output o_FRAME_VALID,
    input  i_FRAME_READY
  );

  modport slave (
    input  o_FRAME_DATA,
    input  o_FRAME_LONG,
    input  o_FRAME_VALID,
    output i_FRAME_READY
  );
endinterface

// File: rtl/uart_frame_receiver.sv
// 8N1 UART deserializer plus tagged sensor-frame reassembly ('A' = 40-bit, 'M'/'a'/'m' = 24-bit).
// Completed frames are held on a valid/ready interface; errors are reported as one-cycle pulses.
module uart_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   i_CLK,
  input  logic                   i_RSTN,
  input  logic                   i_UART_RXD,
  uart_frame_receiver_if.master  frm,
  output logic [3:0]             o_ERR
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_LIMIT);

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_WAIT_HIGH
  } bit_state_t;

  typedef enum logic {
    FR_HDR,
    FR_BODY
  } fr_state_t;

  // Serial input synchronizer, idles high
  logic rxd_meta;
  logic rxd_sync;
  logic rxd_sync_d;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_sync_d <= 1'b1;
    end else begin
      rxd_meta   <= i_UART_RXD;
      rxd_sync   <= rxd_meta;
      rxd_sync_d <= rxd_sync;
    end
  end

  bit_state_t       bit_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       byte_data;
  logic             byte_strobe;
  logic             frame_err;
  logic             start_det_c;

  assign start_det_c = (bit_state == BIT_IDLE) && rxd_sync_d && !rxd_sync;

  // Bit-level receiver: mid-bit sampling, one strobe per good byte
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      bit_state   <= BIT_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_data   <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      case (bit_state)
        BIT_IDLE: begin
          if (start_det_c) begin
            bit_state <= BIT_START;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
          end
        end
        BIT_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt   <= '0;
            bit_state <= rxd_sync ? BIT_IDLE : BIT_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        BIT_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_state <= BIT_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        BIT_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rxd_sync) begin
              byte_strobe <= 1'b1;
              byte_data   <= shreg;
              bit_state   <= BIT_IDLE;
            end else begin
              frame_err <= 1'b1;
              bit_state <= BIT_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        BIT_WAIT_HIGH: begin
          if (rxd_sync) begin
            bit_state <= BIT_IDLE;
          end
        end
        default: bit_state <= BIT_IDLE;
      endcase
    end
  end

  fr_state_t        fr_state;
  logic [39:0]      buf_q;
  logic [2:0]       byte_cnt;
  logic             len_long;
  logic [GAP_W-1:0] gap_cnt;

  logic [39:0] buf_next_c;
  logic [39:0] frame_c;
  logic        hdr_ok_c;
  logic        hdr_err_c;
  logic        last_c;
  logic        complete_c;
  logic        tmo_c;
  logic        ovr_c;

  // Byte placement, completion and error decode for the frame assembler
  always_comb begin
    buf_next_c = buf_q;
    case (byte_cnt)
      3'd1:    buf_next_c[31:24] = byte_data;
      3'd2:    buf_next_c[23:16] = byte_data;
      3'd3:    buf_next_c[15:8]  = byte_data;
      3'd4:    buf_next_c[7:0]   = byte_data;
      default: buf_next_c = buf_q;
    endcase
    frame_c = buf_next_c;
    if (!len_long) begin
      frame_c[15:0] = 16'h0000;
    end
    hdr_ok_c   = (byte_data == 8'h41) || (byte_data == 8'h4D) ||
                 (byte_data == 8'h61) || (byte_data == 8'h6D);
    hdr_err_c  = (fr_state == FR_HDR) && byte_strobe && !hdr_ok_c;
    last_c     = (byte_cnt + 3'd1) == (len_long ? 3'd5 : 3'd3);
    complete_c = (fr_state == FR_BODY) && byte_strobe && last_c;
    tmo_c      = (fr_state == FR_BODY) && (gap_cnt == GAP_MAX) && !byte_strobe && !frame_err;
    ovr_c      = complete_c && frm.o_FRAME_VALID && !frm.i_FRAME_READY;
  end

  // Frame assembler, inter-byte timeout and output holding register
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      fr_state          <= FR_HDR;
      buf_q             <= '0;
      byte_cnt          <= '0;
      len_long          <= 1'b0;
      gap_cnt           <= '0;
      o_ERR             <= '0;
      frm.o_FRAME_DATA  <= '0;
      frm.o_FRAME_LONG  <= 1'b0;
      frm.o_FRAME_VALID <= 1'b0;
    end else begin
      o_ERR <= {ovr_c, tmo_c, hdr_err_c, frame_err};
      case (fr_state)
        FR_HDR: begin
          gap_cnt <= '0;
          if (byte_strobe && hdr_ok_c) begin
            buf_q    <= {byte_data, 32'h0000_0000};
            byte_cnt <= 3'd1;
            len_long <= (byte_data == 8'h41);
            fr_state <= FR_BODY;
          end
        end
        FR_BODY: begin
          if (byte_strobe || start_det_c) begin
            gap_cnt <= '0;
          end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
          if (frame_err || tmo_c || (byte_strobe && last_c)) begin
            fr_state <= FR_HDR;
            byte_cnt <= '0;
            buf_q    <= '0;
          end else if (byte_strobe) begin
            buf_q    <= buf_next_c;
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        default: fr_state <= FR_HDR;
      endcase

      // A completion during acceptance replaces the frame; otherwise it is an overrun
      if (complete_c && !ovr_c) begin
        frm.o_FRAME_DATA  <= frame_c;
        frm.o_FRAME_LONG  <= len_long;
        frm.o_FRAME_VALID <= 1'b1;
      end else if (frm.o_FRAME_VALID && frm.i_FRAME_READY) begin
        frm.o_FRAME_VALID <= 1'b0;
      end
    end
  end

endmodule
